// File: rtl/cycle_pkg.sv
// Shared definitions for the cycle computer: clock rate, button timing and the
// button decoder state encoding (exported so waveforms and benches can decode it).
package cycle_pkg;

    localparam int CLK_HZ           = 32768;
    localparam int LONG_PRESS_TICKS = 2 * CLK_HZ;

    typedef enum logic [2:0] {
        BTN_IDLE,
        BTN_MODE_HELD,
        BTN_TRIP_HELD,
        BTN_BOTH_HELD,
        BTN_WAIT_RELEASE
    } btn_state_t;

    // States in which a single button is down and the hold timer runs.
    function automatic logic is_single_held(btn_state_t s);
        return (s == BTN_MODE_HELD) || (s == BTN_TRIP_HELD);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Saturating hold counter for the button decoder; flags the cycle on which a
// held button qualifies as a long press.
module hold_timer
    import cycle_pkg::*;
#(
    parameter int LONG_TICKS = LONG_PRESS_TICKS
) (
    input  logic clock,
    input  logic nReset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int             CW   = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(LONG_TICKS - 1);

    logic [CW-1:0] count;

    // Stops at LAST so a button held indefinitely never re-arms a long event.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/button_event_decoder.sv
// Turns debounced active-low Mode/Trip levels into one-cycle short, long and
// two-button events, at most one event per press gesture.
module button_event_decoder
    import cycle_pkg::*;
#(
    parameter int LONG_TICKS = LONG_PRESS_TICKS
) (
    input  logic clock,
    input  logic nReset,
    input  logic debounced_nMode,
    input  logic debounced_nTrip,
    output logic mode_press,
    output logic mode_long,
    output logic trip_press,
    output logic trip_long,
    output logic both_press
);

    btn_state_t state_q, state_d;
    logic       terminal;
    logic       mode_press_d, mode_long_d, trip_press_d, trip_long_d, both_press_d;

    wire mode_dn = !debounced_nMode;
    wire trip_dn = !debounced_nTrip;

    // Holding the counter clear in IDLE makes every HELD entry start from zero.
    hold_timer #(
        .LONG_TICKS (LONG_TICKS)
    ) u_hold_timer (
        .clock    (clock),
        .nReset   (nReset),
        .clear    (state_q == BTN_IDLE),
        .enable   (is_single_held(state_q)),
        .terminal (terminal)
    );

    always_comb begin
        state_d      = state_q;
        mode_press_d = 1'b0;
        mode_long_d  = 1'b0;
        trip_press_d = 1'b0;
        trip_long_d  = 1'b0;
        both_press_d = 1'b0;

        // Second button beats long, and long beats a release on the same sample.
        unique case (state_q)
            BTN_IDLE: begin
                if (mode_dn && trip_dn) begin
                    state_d      = BTN_BOTH_HELD;
                    both_press_d = 1'b1;
                end else if (mode_dn) begin
                    state_d = BTN_MODE_HELD;
                end else if (trip_dn) begin
                    state_d = BTN_TRIP_HELD;
                end
            end
            BTN_MODE_HELD: begin
                if (trip_dn) begin
                    state_d      = BTN_BOTH_HELD;
                    both_press_d = 1'b1;
                end else if (terminal) begin
                    state_d     = BTN_WAIT_RELEASE;
                    mode_long_d = 1'b1;
                end else if (!mode_dn) begin
                    state_d      = BTN_IDLE;
                    mode_press_d = 1'b1;
                end
            end
            BTN_TRIP_HELD: begin
                if (mode_dn) begin
                    state_d      = BTN_BOTH_HELD;
                    both_press_d = 1'b1;
                end else if (terminal) begin
                    state_d     = BTN_WAIT_RELEASE;
                    trip_long_d = 1'b1;
                end else if (!trip_dn) begin
                    state_d      = BTN_IDLE;
                    trip_press_d = 1'b1;
                end
            end
            BTN_BOTH_HELD, BTN_WAIT_RELEASE: begin
                if (!mode_dn && !trip_dn) state_d = BTN_IDLE;
            end
            default: state_d = BTN_WAIT_RELEASE;
        endcase
    end

    // Reset parks in WAIT_RELEASE so a button held through reset is swallowed.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= BTN_WAIT_RELEASE;
            mode_press <= 1'b0;
            mode_long  <= 1'b0;
            trip_press <= 1'b0;
            trip_long  <= 1'b0;
            both_press <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_press <= mode_press_d;
            mode_long  <= mode_long_d;
            trip_press <= trip_press_d;
            trip_long  <= trip_long_d;
            both_press <= both_press_d;
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: a LONG_TICKS=16 instance for the
// gesture cases and a default-parameter instance for a real-rate press train.
module tb_button_event_decoder;

    logic clock = 1'b0;
    logic nReset;
    logic nmode, ntrip, rmode, rtrip;
    logic mp, ml, tp, tl, bp;
    logic r_mp, r_ml, r_tp, r_tl, r_bp;

    int n_checks = 0;
    int n_fail   = 0;
    int c_mp, c_ml, c_tp, c_tl, c_bp;
    int rc_mp, rc_tp, rc_other;

    always #5 clock = ~clock;

    button_event_decoder #(.LONG_TICKS(16)) dut (
        .clock           (clock),
        .nReset          (nReset),
        .debounced_nMode (nmode),
        .debounced_nTrip (ntrip),
        .mode_press      (mp),
        .mode_long       (ml),
        .trip_press      (tp),
        .trip_long       (tl),
        .both_press      (bp)
    );

    button_event_decoder dut_real (
        .clock           (clock),
        .nReset          (nReset),
        .debounced_nMode (rmode),
        .debounced_nTrip (rtrip),
        .mode_press      (r_mp),
        .mode_long       (r_ml),
        .trip_press      (r_tp),
        .trip_long       (r_tl),
        .both_press      (r_bp)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clr();
        c_mp = 0; c_ml = 0; c_tp = 0; c_tl = 0; c_bp = 0;
    endtask

    // Advance n edges, sampling 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            c_mp += int'(mp); c_ml += int'(ml); c_tp += int'(tp);
            c_tl += int'(tl); c_bp += int'(bp);
            rc_mp += int'(r_mp); rc_tp += int'(r_tp);
            rc_other += int'(r_ml) + int'(r_tl) + int'(r_bp);
            if ($countones({mp, ml, tp, tl, bp}) > 1)
                chk("exclusive", $countones({mp, ml, tp, tl, bp}), 1);
        end
    endtask

    initial begin
        rc_mp = 0; rc_tp = 0; rc_other = 0;
        clr();
        nReset = 1'b0; nmode = 1'b0; ntrip = 1'b1; rmode = 1'b1; rtrip = 1'b1;
        #3;
        chk("reset_outs", {27'd0, mp, ml, tp, tl, bp}, 0);
        step(2);
        nReset = 1'b1;

        // Mode held across reset: swallowed until released.
        step(5);
        nmode = 1'b1;
        step(3);
        chk("held_reset_events", c_mp + c_ml + c_tp + c_tl + c_bp, 0);
        nmode = 1'b0;
        step(3);
        nmode = 1'b1;
        step(1);
        chk("mode_press_edge", mp, 1);
        step(1);
        chk("mode_press_width", mp, 0);
        chk("mode_press_count", c_mp, 1);

        // Trip 15 cycles: short; Trip 20 cycles: long at edge 16, silent release.
        clr();
        ntrip = 1'b0;
        step(15);
        ntrip = 1'b1;
        step(1);
        chk("trip15_press", tp, 1);
        step(3);
        chk("trip15_no_long", c_tl, 0);
        clr();
        ntrip = 1'b0;
        step(16);
        chk("trip_long_early", c_tl, 0);
        step(1);
        chk("trip_long_edge", tl, 1);
        step(3);
        ntrip = 1'b1;
        step(3);
        chk("trip_long_count", c_tl, 1);
        chk("trip_long_no_press", c_tp, 0);

        // Mode then Trip: both_press when Trip is first seen low.
        clr();
        nmode = 1'b0;
        step(4);
        ntrip = 1'b0;
        step(1);
        chk("both_seq_edge", bp, 1);
        step(2);
        nmode = 1'b1;
        step(3);
        ntrip = 1'b1;
        step(3);
        chk("both_seq_count", c_bp, 1);
        chk("both_seq_no_short", c_mp + c_tp, 0);

        // Simultaneous press held 40 cycles.
        clr();
        nmode = 1'b0; ntrip = 1'b0;
        step(1);
        chk("both_sim_edge", bp, 1);
        step(39);
        nmode = 1'b1; ntrip = 1'b1;
        step(3);
        chk("both_sim_count", c_bp, 1);
        chk("both_sim_no_long", c_ml + c_tl, 0);

        // mode_long, then Trip while Mode still held: ignored; then Trip tap.
        clr();
        nmode = 1'b0;
        step(16);
        step(1);
        chk("mode_long_edge", ml, 1);
        ntrip = 1'b0;
        step(3);
        nmode = 1'b1;
        step(2);
        ntrip = 1'b1;
        step(3);
        chk("wait_release_quiet", c_mp + c_ml + c_tp + c_tl + c_bp, 1);
        ntrip = 1'b0;
        step(2);
        ntrip = 1'b1;
        step(1);
        chk("tap_after_wait", tp, 1);

        // Release on the terminal edge reports long, not short.
        clr();
        nmode = 1'b0;
        step(16);
        nmode = 1'b1;
        step(1);
        chk("release_at_long", {30'd0, ml, mp}, 2);
        step(3);
        chk("release_at_long_cnt", c_mp + c_ml, 1);

        // Reset mid-hold at count 10: outputs clear at once, no event after.
        clr();
        nmode = 1'b0;
        step(11);
        #2 nReset = 1'b0;
        #1;
        chk("midhold_reset_outs", {27'd0, mp, ml, tp, tl, bp}, 0);
        step(2);
        nReset = 1'b1;
        step(3);
        nmode = 1'b1;
        step(20);
        chk("midhold_reset_quiet", c_mp + c_ml + c_tp + c_tl + c_bp, 0);

        // Real-rate train: 3 ms Mode and 4 ms Trip presses with 1 ms gaps.
        rc_mp = 0; rc_tp = 0; rc_other = 0;
        for (int k = 0; k < 3; k++) begin
            rmode = 1'b0; step(98);
            rmode = 1'b1; step(33);
            rtrip = 1'b0; step(131);
            rtrip = 1'b1; step(33);
        end
        chk("train_mode_press", rc_mp, 3);
        chk("train_trip_press", rc_tp, 3);
        chk("train_no_other", rc_other, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
